// File: rtl/plusarg_timeout_monitor.sv
// plusarg_timeout_monitor: idle-cycle watchdog against a plusarg-supplied cycle limit.
// Limit is captured once after reset; expiry is sticky until the next reset.
module plusarg_timeout_monitor #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      limit,
  input  logic             enable,
  input  logic             kick,
  output logic             armed,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             expired_pulse
);
  typedef enum logic [1:0] {LOAD, OFF, RUN, EXPIRED} state_t;
  localparam logic [31:0] MAXV = 32'((64'd1 << WIDTH) - 64'd1);
  state_t           r_state;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] r_count;
  logic             r_armed;
  logic             r_expired;
  logic             r_pulse;
  logic [WIDTH-1:0] w_eff;
  logic             w_hit;
  // Limits beyond the counter range saturate rather than truncate
  assign w_eff = (limit > MAXV) ? MAXV[WIDTH-1:0] : limit[WIDTH-1:0];
  assign w_hit = ((WIDTH+1)'(r_count) + (WIDTH+1)'(1)) == (WIDTH+1)'(r_lim);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= LOAD;
      r_lim     <= '0;
      r_count   <= '0;
      r_armed   <= 1'b0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        LOAD: begin
          r_lim   <= w_eff;
          r_state <= (w_eff == '0) ? OFF : RUN;
          r_armed <= (w_eff != '0);
        end
        RUN: begin
          if (kick) r_count <= '0;
          else if (enable && w_hit) begin
            r_count   <= r_lim;
            r_state   <= EXPIRED;
            r_armed   <= 1'b0;
            r_expired <= 1'b1;
            r_pulse   <= 1'b1;
          end else if (enable) r_count <= r_count + WIDTH'(1);
        end
        default: ;
      endcase
    end
  end
  assign armed         = r_armed;
  assign count         = r_count;
  assign expired       = r_expired;
  assign expired_pulse = r_pulse;
endmodule

// File: tb/tb_plusarg_timeout_monitor.sv
// tb_plusarg_timeout_monitor: vector table plus hand sequences for the watchdog,
// covering a 32-bit instance and a 4-bit instance with a saturated limit.
module tb_plusarg_timeout_monitor;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] limit = '0;
  logic [31:0] limit4 = 32'd100;
  logic        enable = 1'b0;
  logic        kick = 1'b0;
  logic        armed, expired, expired_pulse;
  logic [31:0] count;
  logic        armed4, expired4, pulse4;
  logic [3:0]  count4;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    bit          rst;
    logic [31:0] lim;
    logic        en;
    logic        kk;
    logic        arm;
    logic [31:0] cnt;
    logic        ex;
    logic        pl;
  } vec_t;
  vec_t tv[$];

  plusarg_timeout_monitor #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .limit(limit), .enable(enable), .kick(kick),
    .armed(armed), .count(count), .expired(expired), .expired_pulse(expired_pulse));

  plusarg_timeout_monitor #(.WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .limit(limit4), .enable(enable), .kick(kick),
    .armed(armed4), .count(count4), .expired(expired4), .expired_pulse(pulse4));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic arm, input logic [31:0] cnt,
                     input logic ex, input logic pl);
    total++;
    if ({armed, count, expired, expired_pulse} !== {arm, cnt, ex, pl}) begin
      bad++;
      $display("FAIL %s: got armed=%0b count=%0d expired=%0b pulse=%0b, want armed=%0b count=%0d expired=%0b pulse=%0b",
               name, armed, count, expired, expired_pulse, arm, cnt, ex, pl);
    end
  endtask

  task automatic chk4(input string name, input logic arm, input logic [3:0] cnt,
                      input logic ex, input logic pl);
    total++;
    if ({armed4, count4, expired4, pulse4} !== {arm, cnt, ex, pl}) begin
      bad++;
      $display("FAIL %s: got armed=%0b count=%0d expired=%0b pulse=%0b, want armed=%0b count=%0d expired=%0b pulse=%0b",
               name, armed4, count4, expired4, pulse4, arm, cnt, ex, pl);
    end
  endtask

  task automatic do_reset(input logic [31:0] lim);
    @(negedge clock);
    reset_n = 1'b0;
    limit = lim;
    enable = 1'b0;
    kick = 1'b0;
    #1 chk("reset", 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic step(input string name, input logic en, input logic kk, input logic arm,
                      input logic [31:0] cnt, input logic ex, input logic pl);
    enable = en;
    kick = kk;
    @(posedge clock);
    @(negedge clock);
    chk(name, arm, cnt, ex, pl);
  endtask

  task automatic add(input bit rst, input logic [31:0] lim, input logic en, input logic kk,
                     input logic arm, input logic [31:0] cnt, input logic ex, input logic pl);
    vec_t v;
    v.rst = rst; v.lim = lim; v.en = en; v.kk = kk;
    v.arm = arm; v.cnt = cnt; v.ex = ex; v.pl = pl;
    tv.push_back(v);
  endtask

  initial begin
    // limit=5, free-running enable: LOAD edge, 4 increments, expiry on 5th RUN cycle
    add(1, 5, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 5, 1, 0, 1, i, 0, 0);
    add(0, 5, 1, 0, 0, 5, 1, 1);
    add(0, 5, 1, 0, 0, 5, 1, 0);
    add(0, 5, 1, 1, 0, 5, 1, 0);
    add(0, 5, 0, 0, 0, 5, 1, 0);
    // limit=4: kick at count 3, then kick on the exact expiring cycle, then expire
    add(1, 4, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add(0, 4, 1, 0, 1, i, 0, 0);
    add(0, 4, 1, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add(0, 4, 1, 0, 1, i, 0, 0);
    add(0, 4, 1, 1, 1, 0, 0, 0);
    add(0, 4, 0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add(0, 4, 1, 0, 1, i, 0, 0);
    add(0, 4, 1, 0, 0, 4, 1, 1);
    // limit=6 with enable toggling: count moves only on enabled cycles
    add(1, 6, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      add(0, 6, 1, 0, 1, i, 0, 0);
      add(0, 6, 0, 0, 1, i, 0, 0);
    end
    add(0, 6, 1, 0, 0, 6, 1, 1);
    // limit=1: first enabled non-kick RUN cycle expires
    add(1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 1, 1);
    // limit=0: monitor stays off
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clock);
    foreach (tv[i]) begin
      if (tv[i].rst) do_reset(tv[i].lim);
      step($sformatf("vec%0d", i), tv[i].en, tv[i].kk, tv[i].arm, tv[i].cnt, tv[i].ex, tv[i].pl);
    end

    // limit=0 under 1000 random enable/kick cycles
    do_reset(0);
    for (int i = 0; i < 1000; i++)
      step("off_rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0, 1'b0);

    // WIDTH=4 instance: limit 100 saturates to 15; a later limit change is ignored
    limit4 = 32'd100;
    do_reset(5000);
    enable = 1'b1;
    kick = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk4("w4_load", 1'b1, 4'd0, 1'b0, 1'b0);
    limit4 = 32'd2;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk4($sformatf("w4_cnt%0d", i), 1'b1, 4'(i), 1'b0, 1'b0);
    end
    @(posedge clock);
    @(negedge clock);
    chk4("w4_expire", 1'b0, 4'd15, 1'b1, 1'b1);
    @(posedge clock);
    @(negedge clock);
    chk4("w4_hold", 1'b0, 4'd15, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN at count 3, then re-capture a new limit
    do_reset(10);
    step("ar_load", 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) step("ar_cnt", 1'b1, 1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1 chk("ar_run_clear", 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    limit = 3;
    reset_n = 1'b1;
    step("ar_reload", 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    step("ar_c1", 1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    step("ar_c2", 1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0);
    step("ar_exp", 1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 1'b1);
    step("ar_exp_hold", 1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 1'b0);
    // Asynchronous reset while EXPIRED
    #3 reset_n = 1'b0;
    #1 chk("ar_exp_clear", 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step("ar_reload2", 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
    step("ar_r2c1", 1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
